// File: rtl/tcam_match_reader.sv
// TCAM match-vector reader: captures a match vector on start and streams matching addresses lowest-first.
// Optional popcount output enabled by defining TCAM_MATCH_COUNT_EN.
module tcam_match_reader #(
    parameter int MEMORY_SIZE = 32,
    parameter int ADDR_W      = $clog2(MEMORY_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MEMORY_SIZE-1:0] matched,
    input  logic                   start,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic                   done,
    output logic                   hit,
    output logic [ADDR_W:0]        match_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [MEMORY_SIZE-1:0] r_pending;
    logic                   r_hit;

    logic [ADDR_W-1:0]      w_low_idx;
    logic                   w_found;
    logic [MEMORY_SIZE-1:0] w_pending_next;

    // Priority encoder: first set bit from index 0 upward wins.
    always_comb begin
        w_low_idx = '0;
        w_found   = 1'b0;
        for (int unsigned i = 0; i < MEMORY_SIZE; i++) begin
            if (r_pending[i] && !w_found) begin
                w_found   = 1'b1;
                w_low_idx = i[ADDR_W-1:0];
            end
        end
    end

    always_comb begin
        w_pending_next            = r_pending;
        w_pending_next[w_low_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_hit     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pending <= matched;
                        r_hit     <= |matched;
                        r_state   <= (|matched) ? S_SCAN : S_DONE;
                    end
                end
                S_SCAN: begin
                    if (out_ready) begin
                        r_pending <= w_pending_next;
                        if (w_pending_next == '0) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_SCAN);
    assign out_addr  = (r_state == S_SCAN) ? w_low_idx : '0;
    assign done      = (r_state == S_DONE);
    assign hit       = r_hit;

`ifdef TCAM_MATCH_COUNT_EN
    logic [ADDR_W:0] r_count;
    logic [ADDR_W:0] w_popcount;

    always_comb begin
        w_popcount = '0;
        for (int unsigned i = 0; i < MEMORY_SIZE; i++) begin
            w_popcount = w_popcount + (ADDR_W+1)'(matched[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_count <= w_popcount;
        end
    end

    assign match_count = r_count;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_tcam_match_reader.sv
// Self-checking bench for tcam_match_reader: per-scenario tasks against a queue-based address model.
module tb_tcam_match_reader;

    logic        clk;
    logic        reset;
    logic [31:0] matched;
    logic        start;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic        done;
    logic        hit;
    logic [5:0]  match_count;

    int n_tests;
    int n_fail;

    tcam_match_reader #(.MEMORY_SIZE(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .matched     (matched),
        .start       (start),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .done        (done),
        .hit         (hit),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    function automatic int exp_count(input logic [31:0] v);
`ifdef TCAM_MATCH_COUNT_EN
        return $countones(v);
`else
        return 0;
`endif
    endfunction

    // Runs one search from IDLE; caller is just after a negedge. Returns the cycles from start to done.
    task automatic run_search(input logic [31:0] vec, input int low_first, input bit rand_ready,
                              input bit noise, output int ncyc);
        int         q[$];
        int         cyc;
        bit         r;
        logic [4:0] e_addr;
        logic       e_hit;
        logic [5:0] e_cnt;
        for (int i = 0; i < 32; i++) if (vec[i]) q.push_back(i);
        e_hit = (vec != 0);
        e_cnt = 6'(exp_count(vec));
        matched   = vec;
        start     = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            matched = noise ? ($urandom_range(0, 1) ? 32'h1 : $urandom) : vec;
            if (cyc > 300) begin
                n_tests++; n_fail++;
                $display("FAIL timeout: no done after %0d cycles for vec %h", cyc, vec);
                break;
            end
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_scan: got %b want 1 (cyc %0d)", busy, cyc); end
            n_tests++;
            if (hit !== e_hit) begin n_fail++; $display("FAIL hit_scan: got %b want %b", hit, e_hit); end
            n_tests++;
            if (match_count !== e_cnt) begin n_fail++; $display("FAIL count_scan: got %0d want %0d", match_count, e_cnt); end
            if (q.size() > 0) begin
                e_addr = q[0][4:0];
                n_tests++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL valid: got %b want 1 (cyc %0d)", out_valid, cyc); end
                n_tests++;
                if (out_addr !== e_addr) begin n_fail++; $display("FAIL addr: got %0d want %0d", out_addr, e_addr); end
                n_tests++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b want 0", done); end
                r = (cyc <= low_first) ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
                out_ready = r;
                if (r) void'(q.pop_front());
            end else begin
                n_tests++;
                if (done !== 1'b1) begin n_fail++; $display("FAIL done: got %b want 1 (cyc %0d)", done, cyc); end
                n_tests++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL valid_done: got %b want 0", out_valid); end
                n_tests++;
                if (out_addr !== 5'd0) begin n_fail++; $display("FAIL addr_done: got %0d want 0", out_addr); end
                out_ready = 1'($urandom_range(0, 1));
                break;
            end
        end
        ncyc = cyc;
        @(negedge clk);
        start   = 1'b0;
        matched = '0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after: busy=%b done=%b valid=%b want 0 0 0", busy, done, out_valid);
        end
        n_tests++;
        if (hit !== e_hit) begin n_fail++; $display("FAIL hit_held: got %b want %b", hit, e_hit); end
        n_tests++;
        if (match_count !== e_cnt) begin n_fail++; $display("FAIL count_held: got %0d want %0d", match_count, e_cnt); end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({busy, out_valid, out_addr, done, hit, match_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all 0", {busy, out_valid, out_addr, done, hit, match_count});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL post_reset: busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_single_hit();
        int c;
        run_search(32'h0000_0100, 0, 1'b0, 1'b0, c);
        n_tests++;
        if (c !== 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", c); end
    endtask

    task automatic test_miss();
        int c;
        run_search(32'h0, 0, 1'b0, 1'b0, c);
        n_tests++;
        if (c !== 1) begin n_fail++; $display("FAIL miss_latency: got %0d want 1", c); end
    endtask

    task automatic test_backpressure();
        int c;
        run_search(32'h8000_0005, 2, 1'b0, 1'b0, c);
        n_tests++;
        if (c !== 6) begin n_fail++; $display("FAIL bp_latency: got %0d want 6", c); end
    endtask

    task automatic test_start_while_busy();
        int c;
        run_search(32'h8000_0005, 1, 1'b0, 1'b1, c);
        run_search(32'h0000_1230, 0, 1'b1, 1'b1, c);
    endtask

    task automatic test_all_ones();
        int c;
        run_search(32'hFFFF_FFFF, 0, 1'b0, 1'b0, c);
        n_tests++;
        if (c !== 33) begin n_fail++; $display("FAIL ones_throughput: got %0d want 33", c); end
    endtask

    task automatic test_top_bit();
        int c;
        run_search(32'h8000_0000, 0, 1'b0, 1'b0, c);
    endtask

    task automatic test_back_to_back();
        int c;
        run_search(32'h0000_0003, 0, 1'b0, 1'b0, c);
        run_search(32'h0, 0, 1'b0, 1'b0, c);
        run_search(32'h4000_0001, 0, 1'b1, 1'b0, c);
    endtask

    task automatic test_reset_mid_scan();
        int c;
        matched   = 32'hFFFF_FFFF;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_tests++;
            if (out_valid !== 1'b1 || out_addr !== 5'(k)) begin
                n_fail++;
                $display("FAIL rst_scan_addr: valid=%b addr=%0d want 1 %0d", out_valid, out_addr, k);
            end
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({busy, out_valid, out_addr, done, hit, match_count} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want all 0", {busy, out_valid, out_addr, done, hit, match_count});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL after_abort: done=%b valid=%b busy=%b want 0 0 0", done, out_valid, busy);
            end
        end
        run_search(32'h0000_0420, 0, 1'b0, 1'b0, c);
    endtask

    task automatic test_random();
        int          c;
        logic [31:0] v;
        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom & $urandom & $urandom;
                1:       v = $urandom;
                2:       v = 32'h1 << $urandom_range(0, 31);
                default: v = ($urandom_range(0, 1) != 0) ? 32'h0 : ~($urandom & $urandom);
            endcase
            run_search(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        clk       = 1'b0;
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        matched   = '0;
        test_reset();
        test_single_hit();
        test_miss();
        test_backpressure();
        test_start_while_busy();
        test_all_ones();
        test_top_bit();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
